// File: rtl/sd_arb_pkg.sv
// rtl/sd_arb_pkg.sv - shared types and helpers for the sd card arbiter
package sd_arb_pkg;

    typedef enum logic [2:0] {Idle, Issue, Wait, Miss, Done} ArbState;

    typedef enum logic {OpRead, OpWrite} SdOp;

    typedef struct packed {
        SdOp         op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } Request;

    // Grant index width; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_card_arbiter_if.sv
// rtl/sd_card_arbiter_if.sv - requester and reader-side bus of the arbiter (SD_ARB_STATS_EN adds counters)
interface sd_card_arbiter_if
    import sd_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]    req_read;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ*4-1:0]  req_wmask;
    logic [NUM_REQ-1:0]    req_done;
    logic [31:0]           req_rdata;
    logic [IDX_W-1:0]      grant_idx;

    logic                  rd_o;
    logic                  wr_o;
    logic [31:0]           addr_o;
    logic [31:0]           wdata_o;
    logic [3:0]            wmask_o;
    logic [31:0]           rdata_i;
    logic                  rvalid_i;
    logic                  busy_i;

`ifdef SD_ARB_STATS_EN
    logic [31:0]           stat_hits;
    logic [31:0]           stat_misses;

    modport master (
        input  req_read, req_write, req_addr, req_wdata, req_wmask,
        input  rdata_i, rvalid_i, busy_i,
        output req_done, req_rdata, grant_idx,
        output rd_o, wr_o, addr_o, wdata_o, wmask_o,
        output stat_hits, stat_misses
    );

    modport slave (
        output req_read, req_write, req_addr, req_wdata, req_wmask,
        output rdata_i, rvalid_i, busy_i,
        input  req_done, req_rdata, grant_idx,
        input  rd_o, wr_o, addr_o, wdata_o, wmask_o,
        input  stat_hits, stat_misses
    );
`else
    modport master (
        input  req_read, req_write, req_addr, req_wdata, req_wmask,
        input  rdata_i, rvalid_i, busy_i,
        output req_done, req_rdata, grant_idx,
        output rd_o, wr_o, addr_o, wdata_o, wmask_o
    );

    modport slave (
        output req_read, req_write, req_addr, req_wdata, req_wmask,
        output rdata_i, rvalid_i, busy_i,
        input  req_done, req_rdata, grant_idx,
        input  rd_o, wr_o, addr_o, wdata_o, wmask_o
    );
`endif

endinterface

// File: rtl/sd_card_arbiter_rr_picker.sv
// rtl/sd_card_arbiter_rr_picker.sv - first pending requester at or after a start index, wrapping
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_pending,
    input  logic [IDX_W-1:0]   i_start,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    int w_cand;

    // Walk from the farthest candidate back to the start so the nearest one wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = int'(i_start) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (i_pending[w_cand]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/sd_card_arbiter.sv
// rtl/sd_card_arbiter.sv - round-robin share of one sd_card_reader cache; SD_ARB_STATS_EN adds hit/miss counters
module sd_card_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    sd_card_arbiter_if.master bus
);

    localparam int IDX_W = idx_width(NUM_REQ);

    ArbState            r_state;
    Request             r_req;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_rr;
    logic [NUM_REQ-1:0] r_done;
    logic [31:0]        r_rdata;
    logic               r_issue_rd;
    logic               r_issue_wr;
    logic               r_wait2;

    logic [NUM_REQ-1:0] w_pending;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [NUM_REQ-1:0] w_onehot;
    logic [IDX_W-1:0]   w_next_rr;
    logic               w_wait_done;
    logic               w_wait_miss;

    assign w_pending = bus.req_read | bus.req_write;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_pending (w_pending),
        .i_start   (r_rr),
        .o_found   (w_found),
        .o_idx     (w_pick)
    );

    always_comb begin
        w_onehot          = '0;
        w_onehot[r_grant] = 1'b1;
    end

    assign w_next_rr   = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    assign w_wait_miss = (r_state == Wait) && bus.busy_i;
    // A read that sees neither data nor busy twice in a row is abandoned with zero data.
    assign w_wait_done = (r_state == Wait) && !bus.busy_i &&
                         ((r_req.op == OpWrite) || bus.rvalid_i || r_wait2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= Idle;
            r_req      <= '0;
            r_grant    <= '0;
            r_rr       <= '0;
            r_done     <= '0;
            r_rdata    <= '0;
            r_issue_rd <= 1'b0;
            r_issue_wr <= 1'b0;
            r_wait2    <= 1'b0;
        end else begin
            r_done     <= '0;
            r_issue_rd <= 1'b0;
            r_issue_wr <= 1'b0;
            case (r_state)
                Idle: begin
                    if (!bus.busy_i && w_found) begin
                        r_req.op    <= bus.req_read[w_pick] ? OpRead : OpWrite;
                        r_req.addr  <= bus.req_addr[int'(w_pick)*32 +: 32];
                        r_req.wdata <= bus.req_wdata[int'(w_pick)*32 +: 32];
                        r_req.wmask <= bus.req_wmask[int'(w_pick)*4 +: 4];
                        r_issue_rd  <= bus.req_read[w_pick];
                        r_issue_wr  <= ~bus.req_read[w_pick];
                        r_grant     <= w_pick;
                        r_wait2     <= 1'b0;
                        r_state     <= Issue;
                    end
                end
                Issue: begin
                    r_state <= Wait;
                end
                Wait: begin
                    if (w_wait_miss) begin
                        r_state <= Miss;
                    end else if (w_wait_done) begin
                        r_rdata <= (r_req.op == OpRead && bus.rvalid_i) ? bus.rdata_i : '0;
                        r_done  <= w_onehot;
                        r_state <= Done;
                    end else begin
                        r_wait2 <= 1'b1;
                    end
                end
                Miss: begin
                    if (!bus.busy_i) begin
                        r_rdata <= (r_req.op == OpRead) ? bus.rdata_i : '0;
                        r_done  <= w_onehot;
                        r_state <= Done;
                    end
                end
                Done: begin
                    r_rr    <= w_next_rr;
                    r_state <= Idle;
                end
                default: begin
                    r_state <= Idle;
                end
            endcase
        end
    end

    // During a miss the strobe follows busy so the reader's perform step samples it.
    assign bus.rd_o      = r_issue_rd | ((r_state == Miss) && (r_req.op == OpRead) && bus.busy_i);
    assign bus.wr_o      = r_issue_wr | ((r_state == Miss) && (r_req.op == OpWrite) && bus.busy_i);
    assign bus.addr_o    = r_req.addr;
    assign bus.wdata_o   = r_req.wdata;
    assign bus.wmask_o   = r_req.wmask;
    assign bus.req_done  = r_done;
    assign bus.req_rdata = r_rdata;
    assign bus.grant_idx = r_grant;

`ifdef SD_ARB_STATS_EN
    logic [31:0] r_hits;
    logic [31:0] r_misses;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            if (w_wait_done && (r_hits != '1)) begin
                r_hits <= r_hits + 32'd1;
            end
            if (w_wait_miss && (r_misses != '1)) begin
                r_misses <= r_misses + 32'd1;
            end
        end
    end

    assign bus.stat_hits   = r_hits;
    assign bus.stat_misses = r_misses;
`endif

endmodule

// File: tb/tb_sd_card_arbiter.sv
// tb/tb_sd_card_arbiter.sv - self-checking bench with reader model and completion scoreboard
module tb_sd_card_arbiter;

    localparam int NUM_REQ = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sd_card_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    sd_card_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        bit          rd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reader model controls
    logic init_busy = 1'b0;
    logic miss_mode = 1'b0;
    int   miss_len  = 1;

    logic        m_busy;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_op_rd;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    int          m_cnt;
    int          rd_cmds;
    int          wr_cmds;
    int          n_writes;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;
    logic [3:0]  last_wmask;

    assign bus.busy_i   = m_busy | init_busy;
    assign bus.rvalid_i = m_rvalid;
    assign bus.rdata_i  = m_rdata;

    function automatic logic [31:0] model_data(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'd7);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Level-sampled reader: a strobe seen while idle is a new command.
    always @(posedge clk) begin
        m_rvalid <= 1'b0;
        if (rst) begin
            m_busy     <= 1'b0;
            m_cnt      <= 0;
            m_rdata    <= '0;
            m_op_rd    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_wmask    <= '0;
            rd_cmds    <= 0;
            wr_cmds    <= 0;
            n_writes   <= 0;
            last_waddr <= '0;
            last_wdata <= '0;
            last_wmask <= '0;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                if (m_op_rd && bus.rd_o) begin
                    m_rvalid <= 1'b1;
                    m_rdata  <= model_data(m_addr);
                end
                if (!m_op_rd && bus.wr_o) begin
                    last_waddr <= m_addr;
                    last_wdata <= m_wdata;
                    last_wmask <= m_wmask;
                    n_writes   <= n_writes + 1;
                end
            end
        end else if (!init_busy && (bus.rd_o || bus.wr_o)) begin
            if (bus.rd_o) rd_cmds <= rd_cmds + 1;
            if (bus.wr_o) wr_cmds <= wr_cmds + 1;
            if (miss_mode) begin
                m_busy  <= 1'b1;
                m_cnt   <= miss_len;
                m_op_rd <= bus.rd_o;
                m_addr  <= bus.addr_o;
                m_wdata <= bus.wdata_o;
                m_wmask <= bus.wmask_o;
            end else if (bus.rd_o) begin
                m_rvalid <= 1'b1;
                m_rdata  <= model_data(bus.addr_o);
            end else begin
                last_waddr <= bus.addr_o;
                last_wdata <= bus.wdata_o;
                last_wmask <= bus.wmask_o;
                n_writes   <= n_writes + 1;
            end
        end
    end

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_read  = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        init_busy     = 1'b0;
        miss_mode     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Observes one completion; cycle 1 is the cycle in which the caller drove stimulus.
    task automatic wait_done(input int max_cyc, output bit got, output int lat,
                             output int rdh, output int wrh, output int fall_err,
                             output logic [NUM_REQ-1:0] done_v, output logic [31:0] rdata_v);
        logic prev_busy;
        got = 0; lat = 1; rdh = 0; wrh = 0; fall_err = 0; done_v = '0; rdata_v = '0;
        prev_busy = bus.busy_i;
        while (!got && lat < max_cyc) begin
            @(negedge clk);
            lat++;
            if (bus.rd_o) rdh++;
            if (bus.wr_o) wrh++;
            if (prev_busy && !bus.busy_i && (bus.rd_o || bus.wr_o)) fall_err++;
            prev_busy = bus.busy_i;
            if (bus.req_done != '0) begin
                got     = 1;
                done_v  = bus.req_done;
                rdata_v = bus.req_rdata;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if ({bus.rd_o, bus.wr_o} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {bus.rd_o, bus.wr_o}); else n_pass++;
        n_checks++; if (bus.req_done !== '0) $display("FAIL reset_done: got %b want 0", bus.req_done); else n_pass++;
        n_checks++; if (bus.req_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus.req_rdata); else n_pass++;
        n_checks++; if (bus.grant_idx !== '0) $display("FAIL reset_grant: got %0d want 0", bus.grant_idx); else n_pass++;
        n_checks++; if ({bus.addr_o, bus.wdata_o, bus.wmask_o} !== 68'h0) $display("FAIL reset_payload: got %h %h %h want 0", bus.addr_o, bus.wdata_o, bus.wmask_o); else n_pass++;
    endtask

    task automatic test_hit_read();
        bit got; int lat, rdh, wrh, ferr; logic [NUM_REQ-1:0] dv; logic [31:0] rv; exp_t e;
        do_reset();
        bus.req_addr[31:0] = 32'h0000_0010;
        bus.req_read       = 2'b01;
        sb.push_back('{idx: 0, rdata: 32'hDEADBEEF, rd: 1'b1});
        wait_done(50, got, lat, rdh, wrh, ferr, dv, rv);
        bus.req_read = '0;
        e = sb.pop_front();
        n_checks++; if (got !== 1'b1) $display("FAIL hit_timeout: got %0b want 1", got); else n_pass++;
        n_checks++; if (dv !== onehot(e.idx)) $display("FAIL hit_done: got %b want %b", dv, onehot(e.idx)); else n_pass++;
        n_checks++; if (rv !== e.rdata) $display("FAIL hit_rdata: got %h want %h", rv, e.rdata); else n_pass++;
        n_checks++; if (lat !== 4) $display("FAIL hit_latency: got %0d want 4", lat); else n_pass++;
        n_checks++; if ({rdh, wrh} !== {32'd1, 32'd0}) $display("FAIL hit_strobe_cycles: got rd %0d wr %0d want 1 0", rdh, wrh); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if ({rd_cmds, wr_cmds} !== {32'd1, 32'd0}) $display("FAIL hit_cmds: got rd %0d wr %0d want 1 0", rd_cmds, wr_cmds); else n_pass++;
    endtask

    task automatic test_miss_write();
        bit got; int lat, rdh, wrh, ferr, extra; logic [NUM_REQ-1:0] dv; logic [31:0] rv; exp_t e;
        do_reset();
        miss_mode           = 1'b1;
        miss_len            = 1100;
        bus.req_addr[63:32]  = 32'h0000_0400;
        bus.req_wdata[63:32] = 32'h1234_5678;
        bus.req_wmask[7:4]   = 4'hF;
        bus.req_write        = 2'b10;
        sb.push_back('{idx: 1, rdata: 32'h0, rd: 1'b0});
        wait_done(3000, got, lat, rdh, wrh, ferr, dv, rv);
        bus.req_write = '0;
        e = sb.pop_front();
        n_checks++; if (got !== 1'b1) $display("FAIL miss_timeout: got %0b want 1", got); else n_pass++;
        n_checks++; if (dv !== onehot(e.idx)) $display("FAIL miss_done: got %b want %b", dv, onehot(e.idx)); else n_pass++;
        n_checks++; if (lat !== 4 + 1100) $display("FAIL miss_latency: got %0d want %0d", lat, 4 + 1100); else n_pass++;
        n_checks++; if (wrh !== 1100) $display("FAIL miss_wr_held: got %0d want 1100", wrh); else n_pass++;
        n_checks++; if (rdh !== 0) $display("FAIL miss_no_rd: got %0d want 0", rdh); else n_pass++;
        n_checks++; if (ferr !== 0) $display("FAIL miss_wr_at_fall: got %0d want 0", ferr); else n_pass++;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.req_done != '0) extra++;
        end
        n_checks++; if (extra !== 0) $display("FAIL miss_done_once: got %0d extra want 0", extra); else n_pass++;
        n_checks++; if ({n_writes, wr_cmds} !== {32'd1, 32'd1}) $display("FAIL miss_write_count: got %0d/%0d want 1/1", n_writes, wr_cmds); else n_pass++;
        n_checks++; if ({last_waddr, last_wdata, last_wmask} !== {32'h400, 32'h1234_5678, 4'hF}) $display("FAIL miss_write_payload: got %h %h %h want 400 12345678 f", last_waddr, last_wdata, last_wmask); else n_pass++;
`ifdef SD_ARB_STATS_EN
        n_checks++; if (bus.stat_misses !== 32'd1) $display("FAIL stat_misses: got %0d want 1", bus.stat_misses); else n_pass++;
        n_checks++; if (bus.stat_hits !== 32'd0) $display("FAIL stat_hits: got %0d want 0", bus.stat_hits); else n_pass++;
`endif
    endtask

    task automatic test_contention();
        bit got; int lat, rdh, wrh, ferr; logic [NUM_REQ-1:0] dv; logic [31:0] rv; exp_t e;
        logic [31:0] a0, a1;
        do_reset();
        a0 = 32'h0000_0100;
        a1 = 32'h0000_0204;
        bus.req_addr = {a1, a0};
        bus.req_read = 2'b11;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{idx: k % 2, rdata: model_data((k % 2) ? a1 : a0), rd: 1'b1});
        end
        for (int k = 0; k < 4; k++) begin
            wait_done(50, got, lat, rdh, wrh, ferr, dv, rv);
            if (k == 3) bus.req_read = '0;
            e = sb.pop_front();
            n_checks++; if (got !== 1'b1) $display("FAIL cont_timeout_%0d: got %0b want 1", k, got); else n_pass++;
            n_checks++; if (dv !== onehot(e.idx)) $display("FAIL cont_grant_%0d: got %b want %b", k, dv, onehot(e.idx)); else n_pass++;
            n_checks++; if (rv !== e.rdata) $display("FAIL cont_rdata_%0d: got %h want %h", k, rv, e.rdata); else n_pass++;
        end
        repeat (3) @(negedge clk);
        n_checks++; if (rd_cmds !== 4) $display("FAIL cont_cmds: got %0d want 4", rd_cmds); else n_pass++;
    endtask

    task automatic test_init_holdoff();
        bit got; int lat, rdh, wrh, ferr, viol; logic [NUM_REQ-1:0] dv; logic [31:0] rv; exp_t e;
        do_reset();
        init_busy          = 1'b1;
        bus.req_addr[31:0] = 32'h0000_0010;
        bus.req_read       = 2'b01;
        sb.push_back('{idx: 0, rdata: 32'hDEADBEEF, rd: 1'b1});
        viol = 0;
        repeat (500) begin
            @(negedge clk);
            if (bus.rd_o || bus.wr_o || bus.req_done != '0) viol++;
        end
        n_checks++; if (viol !== 0) $display("FAIL holdoff_quiet: got %0d active cycles want 0", viol); else n_pass++;
        init_busy = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.rd_o !== 1'b1) $display("FAIL holdoff_issue: got %0b want 1", bus.rd_o); else n_pass++;
        wait_done(50, got, lat, rdh, wrh, ferr, dv, rv);
        bus.req_read = '0;
        e = sb.pop_front();
        n_checks++; if (dv !== onehot(e.idx)) $display("FAIL holdoff_done: got %b want %b", dv, onehot(e.idx)); else n_pass++;
        n_checks++; if (rv !== e.rdata) $display("FAIL holdoff_rdata: got %h want %h", rv, e.rdata); else n_pass++;
    endtask

    task automatic test_read_write_same();
        bit got; int lat, rdh, wrh, ferr; logic [NUM_REQ-1:0] dv; logic [31:0] rv; exp_t e;
        do_reset();
        bus.req_addr[31:0]  = 32'h0000_0010;
        bus.req_wdata[31:0] = 32'hCAFE_F00D;
        bus.req_wmask[3:0]  = 4'h3;
        bus.req_read        = 2'b01;
        bus.req_write       = 2'b01;
        sb.push_back('{idx: 0, rdata: 32'hDEADBEEF, rd: 1'b1});
        wait_done(50, got, lat, rdh, wrh, ferr, dv, rv);
        bus.req_read  = '0;
        bus.req_write = '0;
        e = sb.pop_front();
        n_checks++; if (dv !== onehot(e.idx)) $display("FAIL rw_done: got %b want %b", dv, onehot(e.idx)); else n_pass++;
        n_checks++; if (rv !== e.rdata) $display("FAIL rw_rdata: got %h want %h", rv, e.rdata); else n_pass++;
        n_checks++; if ({rdh, wrh} !== {32'd1, 32'd0}) $display("FAIL rw_strobes: got rd %0d wr %0d want 1 0", rdh, wrh); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if ({wr_cmds, n_writes} !== {32'd0, 32'd0}) $display("FAIL rw_no_write: got %0d/%0d want 0/0", wr_cmds, n_writes); else n_pass++;
    endtask

    task automatic test_reset_in_miss();
        bit got; int lat, rdh, wrh, ferr, act; logic [NUM_REQ-1:0] dv; logic [31:0] rv; exp_t e;
        do_reset();
        miss_mode           = 1'b1;
        miss_len            = 200;
        bus.req_addr[63:32] = 32'h0000_0300;
        bus.req_read        = 2'b10;
        sb.push_back('{idx: 1, rdata: model_data(32'h300), rd: 1'b1});
        repeat (50) @(negedge clk);
        n_checks++; if (bus.rd_o !== 1'b1) $display("FAIL rstmiss_rd_held: got %0b want 1", bus.rd_o); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({bus.rd_o, bus.wr_o} !== 2'b00) $display("FAIL rstmiss_strobes: got %b want 00", {bus.rd_o, bus.wr_o}); else n_pass++;
        n_checks++; if (bus.req_done !== '0) $display("FAIL rstmiss_done: got %b want 0", bus.req_done); else n_pass++;
        sb.delete();
        bus.req_read = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        act = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rd_o || bus.wr_o || bus.req_done != '0) act++;
        end
        n_checks++; if (act !== 0) $display("FAIL rstmiss_idle: got %0d active cycles want 0", act); else n_pass++;
        n_checks++; if (bus.grant_idx !== '0) $display("FAIL rstmiss_grant: got %0d want 0", bus.grant_idx); else n_pass++;
        miss_len           = 20;
        bus.req_addr[31:0] = 32'h0000_0044;
        bus.req_read       = 2'b01;
        sb.push_back('{idx: 0, rdata: model_data(32'h44), rd: 1'b1});
        wait_done(200, got, lat, rdh, wrh, ferr, dv, rv);
        bus.req_read = '0;
        e = sb.pop_front();
        n_checks++; if (dv !== onehot(e.idx)) $display("FAIL rstmiss_recover_done: got %b want %b", dv, onehot(e.idx)); else n_pass++;
        n_checks++; if (rv !== e.rdata) $display("FAIL rstmiss_recover_rdata: got %h want %h", rv, e.rdata); else n_pass++;
        n_checks++; if (lat !== 4 + 20) $display("FAIL rstmiss_recover_latency: got %0d want 24", lat); else n_pass++;
    endtask

    initial begin
        bus.req_read  = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        test_reset();
        test_hit_read();
        test_miss_write();
        test_contention();
        test_init_holdoff();
        test_read_write_same();
        test_reset_in_miss();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
